// File: rtl/cordic_pkg.sv
// Shared constants and float field layout for the cosine CORDIC datapath.
package cordic_pkg;

    localparam int FIX_W     = 21;
    localparam int FRAC_W    = 20;
    localparam int ACC_W     = 32;
    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  expo;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/fx2fp_out_stage_if.sv
// Term input stream and float result stream of the fixed-to-float output stage.
// master: the producer/consumer side, slave: the conversion stage itself.
interface fx2fp_out_stage_if #(
    parameter int FIX_W = 21
);

    logic             in_valid;
    logic             in_ready;
    logic [FIX_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/fx_lzc.sv
// Combinational leading-one detect: index of the most significant set bit.
// zero_o flags an all-zero input (lead_o is then 0 and meaningless).
module fx_lzc #(
    parameter int W     = 21,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     value_i,
    output logic [IDX_W-1:0] lead_o,
    output logic             zero_o
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        lead_o = '0;
        zero_o = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (value_i[i]) begin
                lead_o = IDX_W'(i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fx2fp_out_stage.sv
// Output stage of the cosine CORDIC: signed Q1.20 term -> IEEE-754 single,
// three stallable register stages (sign/magnitude, normalise, pack/round).
// Optional feature macro: FX2FP_ACCUM_EN sums a batch of terms (closed by
// in_last) in a Q11.20 accumulator before conversion.
module fx2fp_out_stage #(
    parameter int FIX_W = cordic_pkg::FIX_W,
    parameter int ACC_W = cordic_pkg::ACC_W
) (
    input logic              clock,
    input logic              aclr_n,
    input logic              clk_en,
    fx2fp_out_stage_if.slave bus
);

    import cordic_pkg::*;

`ifdef FX2FP_ACCUM_EN
    localparam int MAG_W = ACC_W;
`else
    localparam int MAG_W = FIX_W;
`endif
    localparam int P_W   = $clog2(MAG_W);
    localparam int EXT_W = MAG_W - 1 + FP_MANT_W + 2;

    logic                    out_valid_q, out_valid_d;
    logic [31:0]             result_q, result_d;
    logic                    stall, advance, accept, load_s1;
    logic signed [MAG_W-1:0] term;

    assign stall         = out_valid_q && !bus.out_ready;
    assign advance       = clk_en && !stall;
    assign accept        = clk_en && aclr_n && bus.in_valid && !stall;
    assign bus.in_ready  = !aclr_n || !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

`ifdef FX2FP_ACCUM_EN
    logic signed [ACC_W-1:0] acc_q, acc_d;

    assign term    = acc_q + ACC_W'($signed(bus.in_data));
    assign load_s1 = accept && bus.in_last;

    // Running batch sum; the closing term hands the total to S1 and clears it.
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = bus.in_last ? '0 : term;
        end
    end

    // Accumulator register.
    always_ff @(posedge clock) begin
        if (!aclr_n) acc_q <= '0;
        else         acc_q <= acc_d;
    end
`else
    assign term    = $signed(bus.in_data);
    assign load_s1 = accept;
`endif

    // ---------------- S1: sign and magnitude ----------------
    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [MAG_W-1:0] s1_mag_q, s1_mag_d;

    // Magnitude keeps full width so the most negative term does not overflow.
    always_comb begin
        s1_valid_d = load_s1;
        s1_sign_d  = term[MAG_W-1];
        s1_mag_d   = s1_sign_d ? $unsigned(-term) : $unsigned(term);
    end

    // S1 register, held while the output is stalled or clk_en is low.
    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
        end else if (advance) begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
        end
    end

    // ---------------- S2: leading-one detect and normalise ----------------
    logic [P_W-1:0]   lead;
    logic             mag_zero;
    logic             s2_valid_q, s2_sign_q, s2_zero_q;
    logic [P_W-1:0]   s2_lead_q;
    logic [MAG_W-2:0] s2_frac_q, s2_frac_d;

    fx_lzc #(.W(MAG_W)) u_lzc (
        .value_i (s1_mag_q),
        .lead_o  (lead),
        .zero_o  (mag_zero)
    );

    // Shift the leading one up to the top and keep only the bits below it.
    always_comb begin
        s2_frac_d = (MAG_W-1)'(s1_mag_q << (P_W'(MAG_W - 1) - lead));
    end

    // S2 register.
    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b1;
            s2_lead_q  <= '0;
            s2_frac_q  <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= mag_zero;
            s2_lead_q  <= lead;
            s2_frac_q  <= s2_frac_d;
        end
    end

    // ---------------- S3: pack, round to nearest even ----------------
    logic [EXT_W-1:0]     ext;
    logic [FP_MANT_W-1:0] mant_raw;
    logic                 guard, sticky, round_up;
    logic [FP_MANT_W:0]   mant_sum;
    logic [FP_EXP_W-1:0]  exp_base;
    fp32_t                fp_d;

    // Zero magnitude packs to +0; a mantissa carry bumps the exponent.
    always_comb begin
        ext      = {s2_frac_q, {(FP_MANT_W + 2){1'b0}}};
        mant_raw = ext[EXT_W-1 -: FP_MANT_W];
        guard    = ext[EXT_W-1-FP_MANT_W];
        sticky   = |ext[EXT_W-2-FP_MANT_W:0];
        round_up = guard && (sticky || mant_raw[0]);
        mant_sum = {1'b0, mant_raw} + {{FP_MANT_W{1'b0}}, round_up};
        exp_base = FP_EXP_W'(FP_BIAS - FRAC_W + int'(s2_lead_q));
        fp_d     = '0;
        if (!s2_zero_q) begin
            fp_d.sign = s2_sign_q;
            fp_d.expo = exp_base + {{(FP_EXP_W-1){1'b0}}, mant_sum[FP_MANT_W]};
            fp_d.mant = mant_sum[FP_MANT_W-1:0];
        end
    end

    // Bubbles clear out_valid but leave the last float on result.
    always_comb begin
        out_valid_d = s2_valid_q;
        result_d    = s2_valid_q ? fp_d : result_q;
    end

    // Output register.
    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (advance) begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_fx2fp_out_stage.sv
// Self-checking bench for fx2fp_out_stage. Expected floats are pushed when a
// term is accepted and popped when the stage hands a result downstream.
// Define FX2FP_ACCUM_EN for both RTL and bench to exercise batch summing.
module tb_fx2fp_out_stage;

    logic clock = 1'b0;
    logic aclr_n;
    logic clk_en;

    fx2fp_out_stage_if #(.FIX_W(21)) bus();

    fx2fp_out_stage #(.FIX_W(21), .ACC_W(32)) dut (
        .clock  (clock),
        .aclr_n (aclr_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] value;
        int          stamp;
    } expect_t;

    expect_t     sbQ[$];
    int          totalChecks = 0;
    int          badChecks   = 0;
    int          advCnt      = 0;
    int          outCount    = 0;
    logic        acceptPending = 1'b0;
    logic        latChecked    = 1'b0;
    logic        lastClkEn     = 1'b1;
    logic        lastAclr      = 1'b0;
    logic        prevValid     = 1'b0;
    logic [31:0] prevResult    = '0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference fixed-to-float: v counts units of 2^-20, round-to-nearest-even.
    function automatic logic [31:0] refFloat(input longint v);
        longint m, keep, rem, half, one;
        int     p, sh;
        logic   s;
        one = 1;
        if (v == 0) return 32'h0;
        s = (v < 0);
        m = s ? -v : v;
        p = 0;
        for (int i = 0; i < 63; i++) if (m[i]) p = i;
        if (p > 23) begin
            sh   = p - 23;
            keep = m >> sh;
            rem  = m & ((one << sh) - 1);
            half = one << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep++;
            if (keep == (one << 24)) begin
                keep = keep >> 1;
                p++;
            end
        end else begin
            keep = m << (23 - p);
        end
        return {s, 8'(127 + p - 20), keep[22:0]};
    endfunction

    // Offer one term, hold it until accepted, then log its expected result.
    task automatic applyStimulus(input logic [20:0] d, input logic last,
                                 input logic [31:0] expVal, input logic pushIt);
        int tries = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        do begin
            @(posedge clock);
            tries++;
        end while (!acceptPending && tries < 200);
        if (!acceptPending) checkOutput("acceptTimeout", 0, 1);
        else if (pushIt) sbQ.push_back('{expVal, advCnt - 1});
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait until every logged result has come out and the output is empty.
    task automatic waitDrain();
        int tries = 0;
        do begin
            @(posedge clock);
            tries++;
        end while ((sbQ.size() != 0 || bus.out_valid) && tries < 500);
        if (sbQ.size() != 0 || bus.out_valid) checkOutput("drainTimeout", 0, 1);
        #1;
    endtask

    // Monitor on the falling edge: results, latency, stall and freeze behaviour.
    always @(negedge clock) begin
        expect_t e;
        if (!aclr_n) begin
            sbQ.delete();
            latChecked    = 1'b0;
            acceptPending = 1'b0;
        end else begin
            if (!lastClkEn && lastAclr) begin
                checkOutput("frozenValid", bus.out_valid, prevValid);
                checkOutput("frozenResult", bus.result, prevResult);
            end
            if (bus.out_valid && !bus.out_ready)
                checkOutput("inReadyStall", bus.in_ready, 0);
            if (bus.out_valid && !latChecked) begin
                if (sbQ.size() == 0) checkOutput("spuriousValid", 1, 0);
                else checkOutput("latency", advCnt - sbQ[0].stamp, 3);
                latChecked = 1'b1;
            end
            if (clk_en && bus.out_valid && bus.out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedOut", 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("result", bus.result, e.value);
                end
                outCount++;
                latChecked = 1'b0;
            end
            acceptPending = clk_en && bus.in_valid && bus.in_ready;
            if (clk_en && !(bus.out_valid && !bus.out_ready)) advCnt++;
        end
        prevValid  = bus.out_valid;
        prevResult = bus.result;
        lastClkEn  = clk_en;
        lastAclr   = aclr_n;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [20:0] basicData[6] = '{21'h080000, 21'h100000, 21'h000001,
                                  21'h1FFFFF, 21'h000000, 21'h09B74E};
    logic [31:0] basicExp[6]  = '{32'h3F000000, 32'hBF800000, 32'h35800000,
                                  32'hB5800000, 32'h00000000, 32'h3F1B74E0};

    initial begin
        int startCount;
        logic [20:0] d;

        aclr_n        = 1'b0;
        clk_en        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        idleCycles(3);
        checkOutput("resetInReady", bus.in_ready, 1);
        checkOutput("resetValid", bus.out_valid, 0);
        checkOutput("resetResult", bus.result, 0);
        aclr_n = 1'b1;

        $display("[TB] basic conversions");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(basicData[i], 1'b1, basicExp[i], 1'b1);
            waitDrain();
        end

        $display("[TB] back-to-back stream with mid-stream stall");
        startCount = outCount;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d = 21'($urandom);
                    applyStimulus(d, 1'b1, refFloat(longint'($signed(d))), 1'b1);
                end
            end
            begin
                idleCycles(5);
                bus.out_ready = 1'b0;
                idleCycles(4);
                bus.out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("streamCount", outCount - startCount, 8);

        $display("[TB] clk_en toggling");
        startCount = outCount;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    d = 21'($urandom);
                    applyStimulus(d, 1'b1, refFloat(longint'($signed(d))), 1'b1);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    @(posedge clock);
                    #1;
                    clk_en = ~clk_en;
                end
                clk_en = 1'b1;
            end
        join
        waitDrain();
        checkOutput("toggleCount", outCount - startCount, 6);

        $display("[TB] reset with terms in flight");
        applyStimulus(21'h040000, 1'b1, 32'h3E800000, 1'b1);
        applyStimulus(21'h0C0000, 1'b1, 32'h3F400000, 1'b1);
        aclr_n = 1'b0;
        idleCycles(1);
        aclr_n = 1'b1;
        checkOutput("postResetValid", bus.out_valid, 0);
        checkOutput("postResetResult", bus.result, 0);
        idleCycles(4);
        checkOutput("flushedValid", bus.out_valid, 0);
        applyStimulus(21'h080000, 1'b1, 32'h3F000000, 1'b1);
        waitDrain();

`ifdef FX2FP_ACCUM_EN
        $display("[TB] accumulate batches");
        for (int i = 0; i < 17; i++) applyStimulus(21'h100000, 1'b0, 32'h0, 1'b0);
        applyStimulus(21'h000001, 1'b1, refFloat(-17 * 64'sd1048576 + 1), 1'b1);
        waitDrain();
        for (int i = 0; i < 17; i++) applyStimulus(21'h100000, 1'b0, 32'h0, 1'b0);
        applyStimulus(21'h000001, 1'b0, 32'h0, 1'b0);
        applyStimulus(21'h000001, 1'b1, refFloat(-17 * 64'sd1048576 + 2), 1'b1);
        waitDrain();
        applyStimulus(21'h080000, 1'b1, 32'h3F000000, 1'b1);
        waitDrain();
`endif

        checkOutput("queueEmpty", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
